adc_sample_ctl: RTL and testbench

Sequencer for the 8-channel SPI ADC capture block. Generates conversion requests from a free-running period timer or an external trigger, and drives the capture block's level-sensitive `start`. It waits for `done`, latches the 128-bit result, and returns `start` low so the capture block re-arms. It sits between the PS register bank or PWM sync and the capture block, and adds overrun, timeout and sample-count bookkeeping.

---
 rtl/adc_ctl_pkg.sv | 23 ++
 rtl/adc_trig_gen.sv | 43 ++++
 rtl/adc_sample_ctl.sv | 139 +++++++++++++
 tb/tb_adc_sample_ctl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ctl_pkg.sv
// Shared types and constants for the ADC sample sequencer and its trigger generator.
package adc_ctl_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_RUN,
        S_LATCH,
        S_REL1,
        S_REL2
    } state_e;

    localparam int ADC_CH   = 8;
    localparam int ADC_BITS = 16;
    localparam int ADC_W    = ADC_CH * ADC_BITS;
    localparam int OVR_W    = 16;

    localparam logic [OVR_W-1:0] OVR_MAX = '1;

    function automatic logic [OVR_W-1:0] sat_inc(input logic [OVR_W-1:0] v);
        return (v == OVR_MAX) ? v : v + OVR_W'(1);
    endfunction

endpackage

// File: rtl/adc_trig_gen.sv
// Conversion request source: free-running period timer or rising edge of an external trigger.
module adc_trig_gen #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    input  logic             trig,
    output logic             req
);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             trig_q;
    logic             tick;

    // A shrunken period that leaves the count past its end wraps silently.
    always_comb begin
        cnt_d = '0;
        tick  = 1'b0;
        if (en && !mode && (period != '0)) begin
            if (cnt_q >= period - CNT_W'(1)) begin
                tick = (cnt_q == period - CNT_W'(1));
            end else begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q  <= '0;
            trig_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            trig_q <= trig;
        end
    end

    assign req = en && (mode ? (trig && !trig_q) : tick);

endmodule

// File: rtl/adc_sample_ctl.sv
// Sequencer for the SPI ADC capture block: issues start, waits for done, latches the
// 128-bit result and keeps overrun, timeout and sample-count bookkeeping.
module adc_sample_ctl
    import adc_ctl_pkg::*;
#(
    parameter int TMO_W = 16,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             en,
    input  logic             mode,
    input  logic [CNT_W-1:0] period,
    input  logic [TMO_W-1:0] timeout,
    input  logic             trig,
    output logic             adc_start,
    input  logic             adc_done,
    input  logic [ADC_W-1:0] adc_data,
    output logic [ADC_W-1:0] data,
    output logic             data_valid,
    output logic             busy,
    output logic             err_tmo,
    output logic [OVR_W-1:0] overruns,
    output logic [CNT_W-1:0] samples,
    input  logic             clr
);

    state_e           state_q, state_d;
    logic             start_q, start_d;
    logic [TMO_W-1:0] tmo_q, tmo_d, tmo_inc;
    logic [ADC_W-1:0] data_q, data_d;
    logic             dv_q, dv_d;
    logic             busy_q, busy_d;
    logic             err_q, err_d;
    logic [OVR_W-1:0] ovr_q, ovr_d;
    logic [CNT_W-1:0] smp_q, smp_d;
    logic             req;

    adc_trig_gen #(
        .CNT_W (CNT_W)
    ) u_trig_gen (
        .clk    (clk),
        .rstn   (rstn),
        .en     (en),
        .mode   (mode),
        .period (period),
        .trig   (trig),
        .req    (req)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= S_IDLE;
            start_q <= 1'b0;
            tmo_q   <= '0;
            data_q  <= '0;
            dv_q    <= 1'b0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
            ovr_q   <= '0;
            smp_q   <= '0;
        end else begin
            state_q <= state_d;
            start_q <= start_d;
            tmo_q   <= tmo_d;
            data_q  <= data_d;
            dv_q    <= dv_d;
            busy_q  <= busy_d;
            err_q   <= err_d;
            ovr_q   <= ovr_d;
            smp_q   <= smp_d;
        end
    end

    always_comb begin
        state_d = state_q;
        start_d = start_q;
        tmo_d   = tmo_q;
        tmo_inc = tmo_q + TMO_W'(1);
        data_d  = data_q;
        dv_d    = 1'b0;
        err_d   = err_q;
        ovr_d   = ovr_q;
        smp_d   = smp_q;

        unique case (state_q)
            S_IDLE: begin
                if (req) begin
                    state_d = S_RUN;
                    start_d = 1'b1;
                    tmo_d   = '0;
                end
            end
            S_RUN: begin
                tmo_d = tmo_inc;
                // done takes priority over a timeout expiring in the same cycle
                if (adc_done) begin
                    state_d = S_LATCH;
                    start_d = 1'b0;
                    data_d  = adc_data;
                    dv_d    = 1'b1;
                    smp_d   = smp_q + CNT_W'(1);
                end else if ((timeout != '0) && (tmo_inc == timeout)) begin
                    state_d = S_REL1;
                    start_d = 1'b0;
                    err_d   = 1'b1;
                end
            end
            S_LATCH: state_d = S_REL1;
            S_REL1:  state_d = S_REL2;
            S_REL2:  state_d = S_IDLE;
            default: begin
                state_d = S_IDLE;
                start_d = 1'b0;
            end
        endcase

        if (req && (state_q != S_IDLE)) begin
            ovr_d = sat_inc(ovr_q);
        end

        if (clr) begin
            err_d = 1'b0;
            ovr_d = '0;
            smp_d = '0;
        end

        busy_d = (state_d != S_IDLE);
    end

    assign adc_start  = start_q;
    assign data       = data_q;
    assign data_valid = dv_q;
    assign busy       = busy_q;
    assign err_tmo    = err_q;
    assign overruns   = ovr_q;
    assign samples    = smp_q;

endmodule

// File: tb/tb_adc_sample_ctl.sv
// Scoreboard bench for adc_sample_ctl with a behavioural capture-block model.
module tb_adc_sample_ctl;

    typedef struct packed {
        logic [127:0] d;
        logic [31:0]  s;
    } exp_t;

    localparam logic [127:0] P1  = 128'h0001_0002_0003_0004_0005_0006_0007_0008;
    localparam logic [127:0] P2  = 128'h1111_2222_3333_4444_5555_6666_7777_8888;
    localparam logic [127:0] P3  = 128'hDEAD_BEEF_0123_4567_89AB_CDEF_FEDC_BA98;
    localparam logic [127:0] P4  = 128'hA5A5_5A5A_0F0F_F0F0_3C3C_C3C3_9999_6666;
    localparam logic [127:0] P5  = 128'h0000_FFFF_0000_FFFF_1234_5678_9ABC_DEF0;
    localparam logic [127:0] P6  = 128'h7FFF_8000_0001_FFFE_4242_2424_1357_2468;
    localparam logic [127:0] PAT = 128'h80A5_70A5_60A5_50A5_40A5_30A5_20A5_10A5;

    logic         clk = 1'b0;
    logic         rstn;
    logic         en;
    logic         mode;
    logic [31:0]  period;
    logic [15:0]  timeout;
    logic         trig;
    logic         adc_start;
    logic         adc_done = 1'b0;
    logic [127:0] adc_data;
    logic [127:0] data;
    logic         data_valid;
    logic         busy;
    logic         err_tmo;
    logic [15:0]  overruns;
    logic [31:0]  samples;
    logic         clr;

    int   checks   = 0;
    int   failures = 0;
    int   cyc      = 0;
    int   done_lat = 0;
    int   mcnt     = 0;
    int   t0;
    exp_t sb[$];
    int   rise_q[$];
    int   fall_q[$];

    adc_sample_ctl #(
        .TMO_W (16),
        .CNT_W (32)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .en         (en),
        .mode       (mode),
        .period     (period),
        .timeout    (timeout),
        .trig       (trig),
        .adc_start  (adc_start),
        .adc_done   (adc_done),
        .adc_data   (adc_data),
        .data       (data),
        .data_valid (data_valid),
        .busy       (busy),
        .err_tmo    (err_tmo),
        .overruns   (overruns),
        .samples    (samples),
        .clr        (clr)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Capture block: raises done done_lat cycles after start rises (never when 0),
    // holds it until start returns low.
    always @(posedge clk) begin
        if (!adc_start) begin
            mcnt     <= 0;
            adc_done <= 1'b0;
        end else begin
            mcnt <= mcnt + 1;
            if (done_lat != 0 && mcnt + 1 >= done_lat) adc_done <= 1'b1;
        end
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic expect_dv(input logic [127:0] d, input logic [31:0] s);
        sb.push_back({d, s});
    endtask

    task automatic trig_pulse();
        trig = 1'b1;
        step(1);
        trig = 1'b0;
        step(1);
    endtask

    task automatic clr_pulse();
        clr = 1'b1;
        step(1);
        clr = 1'b0;
    endtask

    task automatic check_reset_vals(input string tag);
        check({tag, "_start"},    adc_start,  0);
        check({tag, "_data"},     data,       0);
        check({tag, "_dv"},       data_valid, 0);
        check({tag, "_busy"},     busy,       0);
        check({tag, "_err"},      err_tmo,    0);
        check({tag, "_overruns"}, overruns,   0);
        check({tag, "_samples"},  samples,    0);
    endtask

    initial begin
        rstn = 1'b0; en = 1'b0; mode = 1'b0; period = '0; timeout = '0;
        trig = 1'b0; clr = 1'b0; adc_data = '0;

        fork
            begin : monitor
                logic ps, pd;
                exp_t e;
                ps = 1'b0;
                pd = 1'b0;
                forever begin
                    @(negedge clk);
                    if (rstn) begin
                        if (adc_start && !ps) rise_q.push_back(cyc);
                        if (!adc_start && ps) fall_q.push_back(cyc);
                        if (data_valid) begin
                            check("dv_single_cycle", pd, 0);
                            check("dv_expected", sb.size() > 0, 1);
                            if (sb.size() > 0) begin
                                e = sb.pop_front();
                                check("sb_data", data, e.d);
                                check("sb_samples", samples, e.s);
                            end
                        end
                    end
                    ps = adc_start;
                    pd = data_valid;
                end
            end
        join_none

        step(3);
        check_reset_vals("reset");
        rstn = 1'b1;
        step(2);

        // Periodic: period 100, done after 40 cycles
        rise_q.delete();
        adc_data = P1;
        expect_dv(P1, 1); expect_dv(P1, 2); expect_dv(P1, 3);
        period = 100; done_lat = 40; mode = 1'b0; en = 1'b1;
        step(360);
        en = 1'b0;
        step(10);
        check("per_rises", rise_q.size(), 3);
        if (rise_q.size() == 3) begin
            check("per_interval1", rise_q[1] - rise_q[0], 100);
            check("per_interval2", rise_q[2] - rise_q[1], 100);
        end
        check("per_samples", samples, 3);
        check("per_overruns", overruns, 0);
        check("per_busy", busy, 0);
        clr_pulse();
        step(1);
        check("clr_samples", samples, 0);

        // Overrun: period 20, done after 40 cycles
        rise_q.delete();
        adc_data = P2;
        expect_dv(P2, 1); expect_dv(P3, 2);
        period = 20; en = 1'b1;
        step(70);
        adc_data = P3;
        step(60);
        en = 1'b0;
        step(10);
        check("ovr_count", overruns, 4);
        check("ovr_samples", samples, 2);
        check("ovr_rises", rise_q.size(), 2);
        if (rise_q.size() == 2) check("ovr_interval", rise_q[1] - rise_q[0], 60);
        clr_pulse();
        step(1);
        check("clr_overruns", overruns, 0);

        // External trigger held high for 10 cycles
        rise_q.delete();
        mode = 1'b1; en = 1'b1; done_lat = 5;
        adc_data = P4;
        expect_dv(P4, 1);
        step(2);
        trig = 1'b1;
        t0 = cyc;
        step(10);
        trig = 1'b0;
        step(10);
        check("ext_rises", rise_q.size(), 1);
        if (rise_q.size() > 0) check("ext_latency", rise_q[0] - t0, 1);
        check("ext_samples", samples, 1);
        check("ext_overruns", overruns, 0);
        clr_pulse();

        // Timeout 50 with no done
        rise_q.delete(); fall_q.delete();
        done_lat = 0; timeout = 50;
        trig_pulse();
        step(70);
        check("tmo_rises", rise_q.size(), 1);
        check("tmo_falls", fall_q.size(), 1);
        if (rise_q.size() == 1 && fall_q.size() == 1) check("tmo_len", fall_q[0] - rise_q[0], 50);
        check("tmo_err", err_tmo, 1);
        check("tmo_samples", samples, 0);
        check("tmo_busy", busy, 0);
        clr_pulse();
        step(1);
        check("clr_err", err_tmo, 0);

        // Timeout disabled: waits indefinitely
        timeout = 0;
        trig_pulse();
        step(300);
        check("notmo_start", adc_start, 1);
        check("notmo_busy", busy, 1);
        check("notmo_err", err_tmo, 0);
        adc_data = P5;
        expect_dv(P5, 1);
        done_lat = 1;
        step(10);
        check("notmo_done_busy", busy, 0);
        check("notmo_samples", samples, 1);
        clr_pulse();

        // Data path: done lands on the same cycle as the timeout limit
        adc_data = PAT; timeout = 50; done_lat = 49;
        expect_dv(PAT, 1);
        trig_pulse();
        step(70);
        check("dp_data", data, PAT);
        check("dp_err", err_tmo, 0);
        check("dp_samples", samples, 1);

        // Reset mid-RUN
        done_lat = 0; timeout = 0;
        trig_pulse();
        step(5);
        trig_pulse();
        check("prerst_overruns", overruns, 1);
        check("prerst_start", adc_start, 1);
        #2 rstn = 1'b0;
        #1;
        check_reset_vals("midrst");
        step(2);
        rstn = 1'b1;
        step(1);

        // clr coinciding with an overrun
        trig_pulse();
        step(3);
        trig_pulse();
        check("preclr_overruns", overruns, 1);
        trig = 1'b1; clr = 1'b1;
        step(1);
        trig = 1'b0; clr = 1'b0;
        step(1);
        check("clrwin_overruns", overruns, 0);
        check("clrwin_samples", samples, 0);
        check("clrwin_busy", busy, 1);
        adc_data = P6;
        expect_dv(P6, 1);
        done_lat = 1;
        step(10);
        check("final_samples", samples, 1);
        check("final_data", data, P6);
        check("final_busy", busy, 0);
        check("sb_drained", sb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
